if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline; drives the IF/ID pipeline register directly.
- Owns the PC and issues requests to a variable-latency instruction memory over a req/ready handshake.
- Presents the fetched instruction plus PC+4 to IF/ID, and honours hazard-unit freeze and branch redirect from EXE.
- Emits a zero bubble (NOP) whenever no valid instruction is available.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
PC_INC, 4, byte increment between sequential fetches.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
freeze  input  1  hazard-unit stall; IF/ID is not loading this cycle
branch_taken  input  1  redirect request from EXE
branch_addr  input  32  redirect target; bits [1:0] ignored and forced to 0
imem_req  output  1  fetch request; held high until accepted
imem_addr  output  32  fetch address; stable while imem_req=1
imem_ready  input  1  memory accepts request and imem_rdata is valid this cycle
imem_rdata  input  32  instruction word
PC_out  output  32  PC+4 of the presented instruction; 0 when invalid
instruction_out  output  32  presented instruction; 0 when invalid
valid_out  output  1  instruction_out/PC_out carry a real instruction
fetch_busy  output  1  request outstanding and not yet accepted

Behaviour:
- All state updates on posedge clk. rst has highest priority: pc<=RESET_PC, state<=FETCH, hold buffer<=0.
- Reset values of the outputs in the reset cycle are imem_req=1, imem_addr=RESET_PC, valid_out=0, PC_out=0, instruction_out=0.
- An outstanding memory request is abandoned on rst; imem shares the same rst.
- FSM states: FETCH, HOLD, DISCARD.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - While imem_ready=1 (same-cycle acceptance allowed), valid_out=1, instruction_out=imem_rdata, PC_out=pc+PC_INC. These outputs are combinational pass-through.
  - branch_taken: pc<=branch_addr and stay in FETCH if ready=1 (data dropped, valid_out forced 0). Go to DISCARD if ready=0.
  - Otherwise, ready & ~freeze: pc<=pc+PC_INC, stay in FETCH. This gives back-to-back fetch, 1 instr/cycle with zero-wait memory.
  - Otherwise, ready & freeze: capture imem_rdata into the hold buffer, go to HOLD.
  - Otherwise, ~ready: stay in FETCH, valid_out=0, fetch_busy=1.
- HOLD:
  - imem_req=0. valid_out=1, instruction_out=hold buffer, PC_out=pc+PC_INC.
  - branch_taken: pc<=branch_addr, go to FETCH; the buffer is dropped and valid_out is forced 0 this cycle.
  - Otherwise, ~freeze: pc<=pc+PC_INC, go to FETCH.
  - Otherwise, freeze: stay in HOLD.
- DISCARD:
  - imem_req=1, imem_addr = old address (kept in a separate register; pc already holds the target). valid_out=0, fetch_busy=1 until ready.
  - On ready: go to FETCH; the data is discarded.
  - branch_taken again: pc<=new branch_addr and stay in DISCARD; the last redirect wins.
- Priority is rst > branch_taken > freeze. Branch and freeze in the same cycle resolve as branch, matching IF/ID flush-over-freeze.
- The IF/ID register is flushed by the same branch_taken; any bubble presented here is harmless.
- Arithmetic: pc+PC_INC is a 32-bit modulo add; 32'hFFFF_FFFC + 4 wraps to 0 with no flag.
- imem_addr never changes while imem_req=1 and not yet accepted. Verify with an assertion.
- valid_out=0 implies PC_out=0 and instruction_out=0.

Decomposition:
- Shared package if_pkg holds:
  - fetch state enum {FETCH, HOLD, DISCARD};
  - NOP_INSTR = 32'h0;
  - default RESET_PC and PC_INC constants.
- One natural sub-module: pc_reg, a 32-bit register with sync reset to RESET_PC, load enable and load value.
- The FSM, hold buffer and discard-address register stay in the top.

Test Plan:
- Zero-wait memory (ready tied 1), no freeze, 4 cycles after reset -> imem_addr 0,4,8,12; PC_out 4,8,12,16; valid_out=1 every cycle.
- ready low 2 cycles at addr 8 -> imem_addr stays 8, fetch_busy=1, valid_out=0 for 2 cycles; on ready: instruction_out=rdata, PC_out=12.
- freeze high 3 cycles while ready at addr 4, rdata=32'hE3A01005 -> HOLD presents E3A01005/PC_out=8 for all freeze cycles, no new req; on release, next imem_addr=8.
- branch_taken to 32'h0000_0103 while request to 0x10 is pending (ready=0) -> DISCARD keeps imem_addr=0x10 until ready, data dropped (valid_out=0); next request addr=0x100.
- branch_taken with freeze in HOLD -> buffer dropped, next cycle imem_addr=branch target, valid_out=0 in branch cycle.
- rst asserted in DISCARD, then RESET_PC=0xFFFF_FFFC with 2 sequential fetches -> state FETCH, imem_addr=0xFFFFFFFC, then 0x0; PC_out after wrap = 0x4.

Source files
------------

// File: rtl/if_pkg.sv
// if_pkg: shared types and constants for the instruction-fetch stage.
// Holds the fetch FSM state enum, the NOP bubble encoding and the default PC parameters.
package if_pkg;
  typedef enum logic [1:0] {FETCH, HOLD, DISCARD} fetch_state_t;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_PC_INC   = 32'd4;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: 32-bit program counter with sync reset to RESET_PC and load enable.
// Ports: clk, rst (sync, active-high), ld (load enable), d (load value), q (current PC).
module pc_reg
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld,
  input  logic [31:0] d,
  output logic [31:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= RESET_PC;
    else if (ld) q <= d;
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC owner and instruction fetch feeding the IF/ID register.
// Ports: clk, rst; freeze (hazard stall), branch_taken/branch_addr (EXE redirect);
// imem_req/imem_addr/imem_ready/imem_rdata (fetch handshake);
// PC_out/instruction_out/valid_out (IF/ID payload, zero bubble when invalid); fetch_busy.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] PC_INC   = DEF_PC_INC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out,
  output logic [31:0] instruction_out,
  output logic        valid_out,
  output logic        fetch_busy
);
  fetch_state_t state, state_d;
  logic [31:0] pc, pc_d, pc_inc, target, hold_buf, disc_addr;
  logic        pc_ld;
  assign pc_inc = pc + PC_INC;
  assign target = branch_addr & ~32'd3;
  pc_reg #(.RESET_PC(RESET_PC)) u_pc (.clk(clk), .rst(rst), .ld(pc_ld), .d(pc_d), .q(pc));
  always_ff @(posedge clk)
    if (rst) state <= FETCH;
    else state <= state_d;
  // hold_buf keeps a word accepted during a freeze; disc_addr keeps the
  // abandoned address on the bus while the pc already points at the target.
  always_ff @(posedge clk)
    if (rst) begin
      hold_buf  <= '0;
      disc_addr <= '0;
    end else begin
      if (state == FETCH && imem_ready && !branch_taken && freeze) hold_buf <= imem_rdata;
      if (state == FETCH && branch_taken && !imem_ready) disc_addr <= pc;
    end
  always_comb begin
    state_d = state;
    pc_ld   = 1'b0;
    pc_d    = branch_taken ? target : pc_inc;
    case (state)
      FETCH: begin
        pc_ld   = branch_taken | (imem_ready & ~freeze);
        state_d = branch_taken ? (imem_ready ? FETCH : DISCARD) :
                  (imem_ready & freeze) ? HOLD : FETCH;
      end
      HOLD: begin
        pc_ld   = branch_taken | ~freeze;
        state_d = (branch_taken | ~freeze) ? FETCH : HOLD;
      end
      DISCARD: begin
        pc_ld   = branch_taken;
        state_d = imem_ready ? FETCH : DISCARD;
      end
      default: state_d = FETCH;
    endcase
  end
  always_comb begin
    imem_req        = rst | (state != HOLD);
    imem_addr       = rst ? RESET_PC : (state == DISCARD) ? disc_addr : pc;
    valid_out       = ~rst & ~branch_taken & ((state == HOLD) | ((state == FETCH) & imem_ready));
    instruction_out = valid_out ? ((state == HOLD) ? hold_buf : imem_rdata) : NOP_INSTR;
    PC_out          = valid_out ? pc_inc : '0;
    fetch_busy      = imem_req & ~imem_ready;
  end
  a_addr_stable: assert property (@(posedge clk) disable iff (rst)
    (imem_req && !imem_ready) |=> $stable(imem_addr));
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed scoreboard bench for if_fetch_stage (default and wrap-reset instances).
module tb_if_fetch_stage;
  import if_pkg::*;
  logic clk = 1'b1;
  logic rst, freeze, br, rdy;
  logic [31:0] ba, rd;
  logic m_req, m_v, m_busy, w_req, w_v, w_busy;
  logic [31:0] m_addr, m_pc, m_ins, w_addr, w_pc, w_ins;
  typedef struct {
    string       name;
    bit          w;
    logic [98:0] exp;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  if_fetch_stage u_dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(br), .branch_addr(ba),
    .imem_req(m_req), .imem_addr(m_addr), .imem_ready(rdy), .imem_rdata(rd),
    .PC_out(m_pc), .instruction_out(m_ins), .valid_out(m_v), .fetch_busy(m_busy));

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(br), .branch_addr(ba),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(rdy), .imem_rdata(rd),
    .PC_out(w_pc), .instruction_out(w_ins), .valid_out(w_v), .fetch_busy(w_busy));

  always @(negedge clk)
    while (q.size() > 0) begin
      exp_t e;
      logic [98:0] a;
      e = q.pop_front();
      a = e.w ? {w_req, w_addr, w_v, w_pc, w_ins, w_busy} : {m_req, m_addr, m_v, m_pc, m_ins, m_busy};
      if (!e.exp[98]) a[97:66] = e.exp[97:66];
      tests++;
      if (a !== e.exp) begin
        fails++;
        $display("FAIL %s: got req=%b addr=%h v=%b pc=%h ins=%h busy=%b, want req=%b addr=%h v=%b pc=%h ins=%h busy=%b",
                 e.name, a[98], a[97:66], a[65], a[64:33], a[32:1], a[0],
                 e.exp[98], e.exp[97:66], e.exp[65], e.exp[64:33], e.exp[32:1], e.exp[0]);
      end
    end

  task automatic step(input logic r, f, b, input logic [31:0] a, input logic y, input logic [31:0] d,
                      input logic eq, input logic [31:0] ea, input logic ev, input logic [31:0] ep,
                      input logic [31:0] ei, input logic eb, input bit w, input string n);
    rst = r; freeze = f; br = b; ba = a; rdy = y; rd = d;
    q.push_back('{n, w, {eq, ea, ev, ep, ei, eb}});
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, "reset");
  endtask

  initial begin
    #1;
    do_rst();
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, 1, 32'h1000 + i, 1, 4 * i, 1, 4 * i + 4, 32'h1000 + i, 0, 0, "seq");
    do_rst();
    step(0, 0, 0, 0, 1, 32'hA0, 1, 0, 1, 4, 32'hA0, 0, 0, "w_f0");
    step(0, 0, 0, 0, 1, 32'hA4, 1, 4, 1, 8, 32'hA4, 0, 0, "w_f4");
    step(0, 0, 0, 0, 0, 32'h0, 1, 8, 0, 0, 0, 1, 0, "wait1");
    step(0, 0, 0, 0, 0, 32'h0, 1, 8, 0, 0, 0, 1, 0, "wait2");
    step(0, 0, 0, 0, 1, 32'hAABB_CCDD, 1, 8, 1, 12, 32'hAABB_CCDD, 0, 0, "accept");
    do_rst();
    step(0, 0, 0, 0, 1, 32'h5, 1, 0, 1, 4, 32'h5, 0, 0, "h_f0");
    step(0, 1, 0, 0, 1, 32'hE3A0_1005, 1, 4, 1, 8, 32'hE3A0_1005, 0, 0, "capture");
    step(0, 1, 0, 0, 0, 32'h0, 0, 0, 1, 8, 32'hE3A0_1005, 0, 0, "hold1");
    step(0, 1, 0, 0, 0, 32'h0, 0, 0, 1, 8, 32'hE3A0_1005, 0, 0, "hold2");
    step(0, 0, 0, 0, 0, 32'h0, 0, 0, 1, 8, 32'hE3A0_1005, 0, 0, "release");
    step(0, 0, 0, 0, 1, 32'h77, 1, 8, 1, 12, 32'h77, 0, 0, "after_hold");
    do_rst();
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, 1, 32'h2000 + i, 1, 4 * i, 1, 4 * i + 4, 32'h2000 + i, 0, 0, "seq_b");
    step(0, 0, 1, 32'h103, 0, 32'h0, 1, 32'h10, 0, 0, 0, 1, 0, "br_pend");
    step(0, 0, 0, 0, 0, 32'h0, 1, 32'h10, 0, 0, 0, 1, 0, "discard");
    step(0, 0, 0, 0, 1, 32'hDEAD, 1, 32'h10, 0, 0, 0, 0, 0, "drop");
    step(0, 0, 0, 0, 1, 32'h88, 1, 32'h100, 1, 32'h104, 32'h88, 0, 0, "target");
    do_rst();
    step(0, 1, 0, 0, 1, 32'h11, 1, 0, 1, 4, 32'h11, 0, 0, "cap_b");
    step(0, 1, 1, 32'h40, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, "hold_br");
    step(0, 0, 0, 0, 1, 32'h22, 1, 32'h40, 1, 32'h44, 32'h22, 0, 0, "hold_tgt");
    step(0, 0, 1, 32'h80, 0, 32'h0, 1, 32'h44, 0, 0, 0, 1, 0, "to_disc");
    step(1, 0, 0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 0, 0, 1, 1, "rst_disc");
    step(0, 0, 0, 0, 1, 32'h33, 1, 32'hFFFF_FFFC, 1, 0, 32'h33, 0, 1, "wrap0");
    step(0, 0, 0, 0, 1, 32'h44, 1, 0, 1, 4, 32'h44, 0, 1, "wrap1");
    step(0, 0, 1, 32'h201, 1, 32'h55, 1, 8, 0, 0, 0, 0, 0, "br_rdy");
    step(0, 0, 0, 0, 1, 32'h66, 1, 32'h200, 1, 32'h204, 32'h66, 0, 0, "br_next");
    rdy = 0;
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
